id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It registers decoded instruction fields and resolves data forwarding from EX/MEM and MEM/WB. It selects the ALU operands and detects load-use hazards against the instruction in decode. Its outputs drive the ALU's `ctrl`, `in_0` and `in_1`, plus the control bits carried to EX/MEM.

## Interface
- No parameters. Data width is fixed at 32 bits; register indices at 5 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_alu_src`, `id_shift_sel`, `id_uses_rt`  in  1 each  decoded instruction controls from decode.
- `id_ctrl`  in  4  ALU operation code, using the ALU's encoding.
- `id_rs_data`, `id_rt_data`, `id_imm`  in  32 each  register-file read data (write-first) and the sign/zero-extended immediate.
- `id_shamt`  in  5  shift amount field.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  source register indices and final destination index (already selected by decode).
- `hold_i`  in  1  back-end freeze; the whole EX/MEM/WB back end is frozen in the same cycle.
- `flush_i`  in  1  kill the instruction entering this stage.
- `exmem_reg_write`  in  1, `exmem_rd`  in  5, `exmem_result`  in  32  EX/MEM forwarding source.
- `memwb_reg_write`  in  1, `memwb_rd`  in  5, `memwb_data`  in  32  MEM/WB forwarding source.
- `alu_ctrl`  out  4, `alu_in_0`  out  32, `alu_in_1`  out  32  ALU drive.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1 each  registered controls.
- `ex_rd`  out  5, `ex_store_data`  out  32  destination index and forwarded rt value.
- `load_use_o`  out  1  combinational stall request to fetch/decode.

## Operation
- **Update priority at each clock edge.** `rst` > `flush_i` > `hold_i` > `load_use_o` bubble > capture.
  - **rst:** every register cleared, so every output above is 0 after reset.
  - **flush_i:** inserts a bubble. `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` and `alu_ctrl` become 0. Datapath registers are don't-care; the implementation clears them.
  - **hold_i:** all fields are held, except the stored rs/rt data, which are overwritten with the current forwarded values (fwdA/fwdB). A producer retiring from WB during a hold therefore cannot be lost.
  - **load_use_o:** inserts a bubble, same as flush. Decode holds its instruction; the stage does not capture it.
  - **capture:** all `id_*` fields are registered.
- **Forwarding** uses the registered indices rs_q/rt_q.
  - fwdA = `exmem_result` if `exmem_reg_write` and `exmem_rd` != 0 and `exmem_rd` == rs_q.
  - Otherwise fwdA = `memwb_data` under the same condition on the MEM/WB inputs.
  - Otherwise fwdA = stored rs data.
  - fwdB is formed the same way on rt_q.
  - Register 0 is never forwarded. EX/MEM wins over MEM/WB.
- **Operand select.**
  - `alu_in_0` = {27'b0, shamt_q} if shift_sel_q.
  - Else `alu_in_0` = {27'b0, fwdA[4:0]} if `alu_ctrl` ∈ {1010, 1011, 1100} (variable shift; the amount is masked to 5 bits).
  - Else `alu_in_0` = fwdA.
  - `alu_in_1` = imm_q if alu_src_q, else fwdB.
  - `ex_store_data` = fwdB.
- **Load-use hazard.** `load_use_o` = `ex_valid` & `ex_mem_read` & (`ex_rd` != 0) & ((`ex_rd` == `id_rs`) | (`id_uses_rt` & `ex_rd` == `id_rt`)) & `id_valid`.
  - `load_use_o` is gated low while `hold_i` is high.

## Timing
- Instruction latency is one cycle from the `id_*` inputs to the registered outputs.
- Forwarding and operand select are combinational after the register, in the same cycle as the ALU evaluation. There is no added latency.
- `load_use_o` is combinational from the `id_*` inputs and stage state. A load followed by a dependent instruction costs exactly one bubble.
- Simultaneous `flush_i` and `hold_i`: flush wins and the stage becomes a bubble.
- Simultaneous `flush_i` and load-use: the result is one bubble; decode still holds for that cycle because `load_use_o` is asserted.
- `rst` asserted mid-hold: all outputs are 0 on the next edge; the hold state is discarded.
- Holding for N cycles leaves the outputs stable, except that `alu_in_*` may change if a forwarding source changes; the refreshed data stays consistent with that change.

## Test plan
- **Forward priority.** Setup: rs_q=5, `exmem_rd`=5 with `exmem_result`=0x11, `memwb_rd`=5 with `memwb_data`=0x22, both write enables high. Required: `alu_in_0`=0x11. Then drop `exmem_reg_write`. Required: `alu_in_0`=0x22.
- **Register 0 and immediate select.** Setup: rs_q=0, `exmem_rd`=0 with `exmem_result`=0xFF, stored rs data=0. Required: `alu_in_0`=0. Then set alu_src=1 with imm=0xFFFFFFF0. Required: `alu_in_1`=0xFFFFFFF0.
- **Load-use bubble.** Setup: load to r8 is in EX; decode holds add with rs=8, `id_valid`=1. Required: `load_use_o`=1 that cycle. Next edge: `ex_valid`=0 and `ex_reg_write`=0. Following edge: the add is captured.
- **Hold across WB retire.**
  - Setup: rs_q=3 is fed by `memwb_data`=0x1234; `hold_i`=1 for 3 cycles.
  - The MEM/WB producer retires after cycle 1.
  - Required: `alu_in_0` stays 0x1234 through all 3 cycles.
- **Shift handling.**
  - Setup: `alu_ctrl`=1010, shift_sel=0, fwdA=0x00000123. Required: `alu_in_0`=0x3.
  - Then set shift_sel=1 with shamt=7. Required: `alu_in_0`=7.
- **Flush vs hold, then reset.** Setup: `flush_i`=1 and `hold_i`=1 together. Required: `ex_valid`=0 next cycle. Then assert `rst` mid-stream. Required: all outputs 0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decoded fields, freeze/flush, forwarding sources, ALU drive and stall request.
// The stage connects through `slave`; decode and the back end sit on `master`.
interface id_ex_stage_if;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
  logic        id_branch, id_alu_src, id_shift_sel, id_uses_rt;
  logic [3:0]  id_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic        hold_i, flush_i;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in_0, alu_in_1;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        load_use_o;

  modport master (
    output id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src,
           id_shift_sel, id_uses_rt, id_ctrl, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd, hold_i, flush_i, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  alu_ctrl, alu_in_0, alu_in_1, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_rd, ex_store_data, load_use_o
  );

  modport slave (
    input  id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src,
           id_shift_sel, id_uses_rt, id_ctrl, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd, hold_i, flush_i, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output alu_ctrl, alu_in_0, alu_in_1, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_rd, ex_store_data, load_use_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register with EX/MEM and MEM/WB forwarding, ALU operand select and load-use detection.
// One cycle id_* -> ex_*; hold freezes fields but refreshes operand data; load-use inserts one bubble.
module id_ex_stage (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        shift_sel;
    logic [3:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  stage_t      q, cap;
  logic [31:0] fwd_a, fwd_b;
  logic        load_use, var_shift;

  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] stored,
    input logic        em_we,
    input logic [4:0]  em_rd,
    input logic [31:0] em_dat,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_dat
  );
    if (em_we && em_rd != 5'd0 && em_rd == idx)      return em_dat;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == idx) return mw_dat;
    else                                             return stored;
  endfunction

  always_comb begin
    cap           = '0;
    cap.valid     = bus.id_valid;
    cap.reg_write = bus.id_reg_write;
    cap.mem_read  = bus.id_mem_read;
    cap.mem_write = bus.id_mem_write;
    cap.branch    = bus.id_branch;
    cap.alu_src   = bus.id_alu_src;
    cap.shift_sel = bus.id_shift_sel;
    cap.ctrl      = bus.id_ctrl;
    cap.rs_data   = bus.id_rs_data;
    cap.rt_data   = bus.id_rt_data;
    cap.imm       = bus.id_imm;
    cap.shamt     = bus.id_shamt;
    cap.rs        = bus.id_rs;
    cap.rt        = bus.id_rt;
    cap.rd        = bus.id_rd;
  end

  assign fwd_a = fwd_sel(q.rs, q.rs_data, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                         bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
  assign fwd_b = fwd_sel(q.rt, q.rt_data, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                         bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);

  // A frozen back end cannot drain the load, so no stall is requested while holding.
  assign load_use = q.valid && q.mem_read && (q.rd != 5'd0) && bus.id_valid && !bus.hold_i &&
                    ((q.rd == bus.id_rs) || (bus.id_uses_rt && q.rd == bus.id_rt));

  // Refreshing operand data during hold keeps a value that retires from WB mid-freeze.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      q <= '0;
    end else if (bus.hold_i) begin
      q.rs_data <= fwd_a;
      q.rt_data <= fwd_b;
    end else if (load_use) begin
      q <= '0;
    end else begin
      q <= cap;
    end
  end

  assign var_shift = (q.ctrl == 4'b1010) || (q.ctrl == 4'b1011) || (q.ctrl == 4'b1100);

  assign bus.alu_ctrl      = q.ctrl;
  assign bus.alu_in_0      = q.shift_sel ? {27'b0, q.shamt} :
                             var_shift   ? {27'b0, fwd_a[4:0]} : fwd_a;
  assign bus.alu_in_1      = q.alu_src ? q.imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_valid      = q.valid;
  assign bus.ex_reg_write  = q.reg_write;
  assign bus.ex_mem_read   = q.mem_read;
  assign bus.ex_mem_write  = q.mem_write;
  assign bus.ex_branch     = q.branch;
  assign bus.ex_rd         = q.rd;
  assign bus.load_use_o    = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: operand/forwarding vector table plus load-use, hold, flush and reset sequences.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic        alu_src;
    logic        shift_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        em_we;
    logic [4:0]  em_rd;
    logic [31:0] em_res;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_dat;
    logic [31:0] exp_in0;
    logic [31:0] exp_in1;
    logic [31:0] exp_store;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_branch = 0; bus.id_alu_src = 0; bus.id_shift_sel = 0; bus.id_uses_rt = 0;
    bus.id_ctrl = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_shamt = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.hold_i = 0; bus.flush_i = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_ctrl"}, {28'b0, bus.alu_ctrl}, 0);
    chk({tag, "_alu_in_0"}, bus.alu_in_0, 0);
    chk({tag, "_alu_in_1"}, bus.alu_in_1, 0);
    chk({tag, "_ex_valid"}, {31'b0, bus.ex_valid}, 0);
    chk({tag, "_ex_reg_write"}, {31'b0, bus.ex_reg_write}, 0);
    chk({tag, "_ex_mem_read"}, {31'b0, bus.ex_mem_read}, 0);
    chk({tag, "_ex_mem_write"}, {31'b0, bus.ex_mem_write}, 0);
    chk({tag, "_ex_branch"}, {31'b0, bus.ex_branch}, 0);
    chk({tag, "_ex_rd"}, {27'b0, bus.ex_rd}, 0);
    chk({tag, "_ex_store_data"}, bus.ex_store_data, 0);
    chk({tag, "_load_use"}, {31'b0, bus.load_use_o}, 0);
  endtask

  initial begin
    //         ctrl   src  sh   rs     rt     rs_data        rt_data        imm            shamt  emwe emrd   em_res         mwwe mwrd   mw_dat         in0            in1            store
    vt[0]  = '{4'h0, 1'b0,1'b0,5'd5, 5'd6, 32'h0000AAAA, 32'h00000066, 32'h0,        5'd0, 1'b1,5'd5, 32'h00000011, 1'b1,5'd5, 32'h00000022, 32'h00000011, 32'h00000066, 32'h00000066};
    vt[1]  = '{4'h0, 1'b0,1'b0,5'd5, 5'd6, 32'h0000AAAA, 32'h00000066, 32'h0,        5'd0, 1'b0,5'd5, 32'h00000011, 1'b1,5'd5, 32'h00000022, 32'h00000022, 32'h00000066, 32'h00000066};
    vt[2]  = '{4'h0, 1'b1,1'b0,5'd0, 5'd0, 32'h00000000, 32'h00000077, 32'hFFFFFFF0, 5'd0, 1'b1,5'd0, 32'h000000FF, 1'b0,5'd0, 32'h00000000, 32'h00000000, 32'hFFFFFFF0, 32'h00000077};
    vt[3]  = '{4'hA, 1'b0,1'b0,5'd2, 5'd4, 32'h00000123, 32'h00000001, 32'h0,        5'd0, 1'b0,5'd0, 32'h00000000, 1'b1,5'd4, 32'h0000BEEF, 32'h00000003, 32'h0000BEEF, 32'h0000BEEF};
    vt[4]  = '{4'hA, 1'b0,1'b1,5'd2, 5'd4, 32'h00000123, 32'h00000001, 32'h0,        5'd7, 1'b0,5'd0, 32'h00000000, 1'b0,5'd0, 32'h00000000, 32'h00000007, 32'h00000001, 32'h00000001};
    vt[5]  = '{4'hB, 1'b0,1'b0,5'd9, 5'd1, 32'h00000000, 32'h00000002, 32'h0,        5'd0, 1'b1,5'd9, 32'hFFFFFFE4, 1'b0,5'd0, 32'h00000000, 32'h00000004, 32'h00000002, 32'h00000002};
    vt[6]  = '{4'hC, 1'b0,1'b0,5'd9, 5'd10,32'h00000000, 32'h00000003, 32'h0,        5'd0, 1'b1,5'd10,32'h00000500, 1'b1,5'd9, 32'h0000003F, 32'h0000001F, 32'h00000500, 32'h00000500};
    vt[7]  = '{4'h2, 1'b0,1'b0,5'd9, 5'd9, 32'h00000000, 32'h00000000, 32'h0,        5'd0, 1'b1,5'd9, 32'h12345678, 1'b0,5'd0, 32'h00000000, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[8]  = '{4'hD, 1'b0,1'b0,5'd2, 5'd3, 32'h00000123, 32'h00000004, 32'h0,        5'd0, 1'b0,5'd0, 32'h00000000, 1'b0,5'd0, 32'h00000000, 32'h00000123, 32'h00000004, 32'h00000004};
    vt[9]  = '{4'h0, 1'b0,1'b0,5'd0, 5'd0, 32'h00000009, 32'h00000008, 32'h0,        5'd0, 1'b1,5'd0, 32'h00000066, 1'b1,5'd0, 32'h00000055, 32'h00000009, 32'h00000008, 32'h00000008};
    vt[10] = '{4'h2, 1'b1,1'b0,5'd7, 5'd7, 32'h00000000, 32'h00000000, 32'h00000020, 5'd9, 1'b1,5'd7, 32'h00000010, 1'b0,5'd0, 32'h00000000, 32'h00000010, 32'h00000020, 32'h00000010};

    clear_inputs();
    rst = 1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 0;

    foreach (vt[i]) begin
      bus.id_valid = 1; bus.id_reg_write = 1;
      bus.id_ctrl = vt[i].ctrl; bus.id_alu_src = vt[i].alu_src; bus.id_shift_sel = vt[i].shift_sel;
      bus.id_rs = vt[i].rs; bus.id_rt = vt[i].rt; bus.id_rd = 5'd20;
      bus.id_rs_data = vt[i].rs_data; bus.id_rt_data = vt[i].rt_data;
      bus.id_imm = vt[i].imm; bus.id_shamt = vt[i].shamt;
      bus.exmem_reg_write = vt[i].em_we; bus.exmem_rd = vt[i].em_rd; bus.exmem_result = vt[i].em_res;
      bus.memwb_reg_write = vt[i].mw_we; bus.memwb_rd = vt[i].mw_rd; bus.memwb_data = vt[i].mw_dat;
      tick();
      chk($sformatf("vec%0d_ex_valid", i), {31'b0, bus.ex_valid}, 1);
      chk($sformatf("vec%0d_alu_ctrl", i), {28'b0, bus.alu_ctrl}, {28'b0, vt[i].ctrl});
      chk($sformatf("vec%0d_alu_in_0", i), bus.alu_in_0, vt[i].exp_in0);
      chk($sformatf("vec%0d_alu_in_1", i), bus.alu_in_1, vt[i].exp_in1);
      chk($sformatf("vec%0d_store", i), bus.ex_store_data, vt[i].exp_store);
    end

    // Load to r8 in EX, dependent add in decode.
    clear_inputs();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_rd = 5'd8;
    bus.id_rs = 5'd1; bus.id_ctrl = 4'h2;
    tick();
    bus.id_mem_read = 0; bus.id_rd = 5'd9; bus.id_rs = 5'd3; bus.id_rt = 5'd8; bus.id_uses_rt = 0;
    #1;
    chk("lu_rt_unused", {31'b0, bus.load_use_o}, 0);
    bus.id_uses_rt = 1;
    #1;
    chk("lu_rt_used", {31'b0, bus.load_use_o}, 1);
    bus.id_rs = 5'd8; bus.id_rt = 5'd2;
    #1;
    chk("lu_rs", {31'b0, bus.load_use_o}, 1);
    tick();
    chk("lu_bubble_valid", {31'b0, bus.ex_valid}, 0);
    chk("lu_bubble_reg_write", {31'b0, bus.ex_reg_write}, 0);
    chk("lu_after_bubble", {31'b0, bus.load_use_o}, 0);
    tick();
    chk("lu_capture_valid", {31'b0, bus.ex_valid}, 1);
    chk("lu_capture_rd", {27'b0, bus.ex_rd}, 9);

    // Hold across MEM/WB retire; held instruction is a load to r12.
    clear_inputs();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_rs = 5'd3; bus.id_rd = 5'd12;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'h1234;
    tick();
    bus.id_mem_read = 0; bus.id_rs = 5'd12; bus.id_rd = 5'd13;
    bus.hold_i = 1;
    #1;
    chk("hold_lu_gated", {31'b0, bus.load_use_o}, 0);
    chk("hold_c1_in0", bus.alu_in_0, 32'h1234);
    tick();
    bus.memwb_reg_write = 0; bus.memwb_data = 32'hDEAD;
    #1;
    chk("hold_c2_in0", bus.alu_in_0, 32'h1234);
    chk("hold_c2_rd", {27'b0, bus.ex_rd}, 12);
    tick();
    chk("hold_c3_in0", bus.alu_in_0, 32'h1234);
    chk("hold_c3_valid", {31'b0, bus.ex_valid}, 1);
    tick();
    chk("hold_end_in0", bus.alu_in_0, 32'h1234);
    bus.hold_i = 0;
    #1;
    chk("hold_release_lu", {31'b0, bus.load_use_o}, 1);

    // Flush together with load-use: a single bubble, then the dependent instruction enters.
    bus.flush_i = 1;
    #1;
    chk("flush_lu_asserted", {31'b0, bus.load_use_o}, 1);
    tick();
    bus.flush_i = 0;
    #1;
    chk("flush_lu_bubble", {31'b0, bus.ex_valid}, 0);
    tick();
    chk("flush_lu_capture", {27'b0, bus.ex_rd}, 13);

    // Flush beats hold, then reset while holding.
    bus.flush_i = 1; bus.hold_i = 1;
    tick();
    chk("fh_valid", {31'b0, bus.ex_valid}, 0);
    chk("fh_ctrl", {28'b0, bus.alu_ctrl}, 0);
    chk("fh_reg_write", {31'b0, bus.ex_reg_write}, 0);
    clear_inputs();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_write = 1; bus.id_branch = 1;
    bus.id_ctrl = 4'h5; bus.id_rs = 5'd4; bus.id_rs_data = 32'h77; bus.id_rt = 5'd5;
    bus.id_rt_data = 32'h88; bus.id_rd = 5'd6;
    tick();
    chk("pre_rst_mem_write", {31'b0, bus.ex_mem_write}, 1);
    chk("pre_rst_in0", bus.alu_in_0, 32'h77);
    rst = 1; bus.hold_i = 1;
    tick();
    check_all_zero("rst_mid_hold");
    rst = 0;
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
